// File: rtl/spi_bit_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_bit_reg_arbiter_if : SPI write/read path, local requesters, bank outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_bit_reg_arbiter_if #(
  parameter int NBITS = 400,
  parameter int AW    = 9,
  parameter int NREQ  = 2
);
  logic                 spi_cs_n;
  logic                 spi_wr_stb;
  logic [AW-1:0]        spi_wr_addr;
  logic                 spi_wr_data;
  logic [AW-1:0]        spi_rd_addr;
  logic                 spi_rd_data;
  logic [NREQ-1:0]      loc_req;
  logic [NREQ*AW-1:0]   loc_addr;
  logic [NREQ-1:0]      loc_data;
  logic [NREQ-1:0]      loc_gnt;
  logic [NBITS-1:0]     reg_bits;
  logic                 viol_pulse;
  logic [7:0]           viol_cnt;
  logic                 busy;

  modport slave (
    input  spi_cs_n, spi_wr_stb, spi_wr_addr, spi_wr_data, spi_rd_addr,
    input  loc_req, loc_addr, loc_data,
    output spi_rd_data, loc_gnt, reg_bits, viol_pulse, viol_cnt, busy
  );

  modport master (
    output spi_cs_n, spi_wr_stb, spi_wr_addr, spi_wr_data, spi_rd_addr,
    output loc_req, loc_addr, loc_data,
    input  spi_rd_data, loc_gnt, reg_bits, viol_pulse, viol_cnt, busy
  );
endinterface

`default_nettype wire

// File: rtl/spi_bit_reg_arbiter.sv
// ---------------------------------------------------------------------------
// spi_bit_reg_arbiter : bit bank shared by SPI (fixed priority) and RR locals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_bit_reg_arbiter #(
  parameter int NBITS           = 400,
  parameter int AW              = 9,
  parameter int NREQ            = 2,
  parameter int CTRL_TOP        = 200,
  parameter int LOCK_DURING_SPI = 1,
  parameter int SETTLE_CYC      = 4
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  spi_bit_reg_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [AW:0]   c_nbits    = (AW+1)'(NBITS);
  localparam logic [AW:0]   c_ctrl_top = (AW+1)'(CTRL_TOP);
  localparam logic [CW-1:0] c_settle_ld = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SPI_LOCK = 2'd1,
    S_SETTLE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [NBITS-1:0] r_bits;
  logic [NREQ-1:0]  r_gnt;
  logic [PW-1:0]    r_ptr;
  logic             r_vpulse;
  logic [7:0]       r_vcnt;

  logic             w_spi_ok;
  logic             w_spi_viol;
  logic             w_loc_elig;
  logic             w_found;
  logic [PW-1:0]    w_sel;
  logic [PW-1:0]    w_ptr_nxt;
  logic [AW-1:0]    w_sel_addr;
  logic             w_sel_data;
  logic             w_loc_fire;
  logic             w_loc_ok;
  logic             w_loc_viol;

  assign w_spi_ok   = bus.spi_wr_stb && ({1'b0, bus.spi_wr_addr} < c_ctrl_top)
                                     && ({1'b0, bus.spi_wr_addr} < c_nbits);
  assign w_spi_viol = bus.spi_wr_stb && !w_spi_ok;

  // Any grant blocks the next cycle, so a request held across its grant is not re-served.
  assign w_loc_elig = ((r_state == S_IDLE) || (LOCK_DURING_SPI == 0))
                      && !bus.spi_wr_stb && (r_gnt == '0);

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && bus.loc_req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_sel   = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
    w_sel_addr = bus.loc_addr[int'(w_sel)*AW +: AW];
    w_sel_data = bus.loc_data[w_sel];
    w_ptr_nxt  = PW'((int'(w_sel) + 1) % NREQ);
  end

  assign w_loc_fire = w_loc_elig && w_found;
  assign w_loc_ok   = ({1'b0, w_sel_addr} >= c_ctrl_top) && ({1'b0, w_sel_addr} < c_nbits);
  assign w_loc_viol = w_loc_fire && !w_loc_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits   <= '0;
      r_gnt    <= '0;
      r_ptr    <= '0;
      r_vpulse <= 1'b0;
      r_vcnt   <= 8'd0;
    end else begin
      r_gnt    <= '0;
      r_vpulse <= w_spi_viol || w_loc_viol;
      if ((w_spi_viol || w_loc_viol) && (r_vcnt != 8'hFF))
        r_vcnt <= r_vcnt + 8'd1;
      if (w_spi_ok)
        r_bits[bus.spi_wr_addr] <= bus.spi_wr_data;
      if (w_loc_fire) begin
        r_gnt[w_sel] <= 1'b1;
        r_ptr        <= w_ptr_nxt;
        if (w_loc_ok)
          r_bits[w_sel_addr] <= w_sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.spi_cs_n)
            r_state <= S_SPI_LOCK;
        end
        S_SPI_LOCK: begin
          if (bus.spi_cs_n) begin
            r_state <= (SETTLE_CYC == 0) ? S_IDLE : S_SETTLE;
            r_cnt   <= c_settle_ld;
          end
        end
        S_SETTLE: begin
          if (!bus.spi_cs_n)
            r_state <= S_SPI_LOCK;
          else if (r_cnt == '0)
            r_state <= S_IDLE;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.spi_rd_data = ({1'b0, bus.spi_rd_addr} < c_nbits) ? r_bits[bus.spi_rd_addr] : 1'b0;
  assign bus.loc_gnt     = r_gnt;
  assign bus.reg_bits    = r_bits;
  assign bus.viol_pulse  = r_vpulse;
  assign bus.viol_cnt    = r_vcnt;
  assign bus.busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_bit_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_bit_reg_arbiter : directed stimulus, queue scoreboard on grant/violation events
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_bit_reg_arbiter;
  localparam int NBITS = 400;
  localparam int AW    = 9;
  localparam int NREQ  = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] gnt;
    logic       vp;
    logic [7:0] vc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  logic [NBITS-1:0] exp_a;
  logic [NBITS-1:0] exp_b;
  logic [7:0]       exp_vc;

  spi_bit_reg_arbiter_if #(.NBITS(NBITS), .AW(AW), .NREQ(NREQ)) ifa ();
  spi_bit_reg_arbiter_if #(.NBITS(NBITS), .AW(AW), .NREQ(NREQ)) ifb ();

  spi_bit_reg_arbiter #(.NBITS(NBITS), .AW(AW), .NREQ(NREQ), .CTRL_TOP(200),
                        .LOCK_DURING_SPI(1), .SETTLE_CYC(4))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  spi_bit_reg_arbiter #(.NBITS(NBITS), .AW(AW), .NREQ(NREQ), .CTRL_TOP(200),
                        .LOCK_DURING_SPI(0), .SETTLE_CYC(4))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int c, input logic [1:0] g, input logic vp, input logic [7:0] vc);
    exp_t e;
    e.cyc = c; e.gnt = g; e.vp = vp; e.vc = vc;
    qa.push_back(e);
  endtask

  // Monitors: every grant or violation pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (ifa.loc_gnt != 2'b00 || ifa.viol_pulse) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: cyc=%0d gnt=%b vp=%b vc=%0d, required no event",
                 cyc, ifa.loc_gnt, ifa.viol_pulse, ifa.viol_cnt);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_cyc", NBITS'(cyc), NBITS'(e.cyc));
        chk("a_gnt", NBITS'(ifa.loc_gnt), NBITS'(e.gnt));
        chk("a_vpulse", NBITS'(ifa.viol_pulse), NBITS'(e.vp));
        chk("a_vcnt", NBITS'(ifa.viol_cnt), NBITS'(e.vc));
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.loc_gnt != 2'b00 || ifb.viol_pulse) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: cyc=%0d gnt=%b vp=%b, required no event",
                 cyc, ifb.loc_gnt, ifb.viol_pulse);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_cyc", NBITS'(cyc), NBITS'(e.cyc));
        chk("b_gnt", NBITS'(ifb.loc_gnt), NBITS'(e.gnt));
        chk("b_vpulse", NBITS'(ifb.viol_pulse), NBITS'(e.vp));
      end
    end
  end

  initial begin
    int c;
    exp_t eb;
    rst_n = 1'b0;
    ifa.spi_cs_n = 1'b1; ifa.spi_wr_stb = 1'b0; ifa.spi_wr_addr = '0; ifa.spi_wr_data = 1'b0;
    ifa.spi_rd_addr = '0; ifa.loc_req = '0; ifa.loc_addr = '0; ifa.loc_data = '0;
    ifb.spi_cs_n = 1'b1; ifb.spi_wr_stb = 1'b0; ifb.spi_wr_addr = '0; ifb.spi_wr_data = 1'b0;
    ifb.spi_rd_addr = '0; ifb.loc_req = '0; ifb.loc_addr = '0; ifb.loc_data = '0;
    exp_a = '0; exp_b = '0; exp_vc = 8'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_bits", ifa.reg_bits, '0);
    chk("rst_gnt", NBITS'(ifa.loc_gnt), '0);
    chk("rst_vcnt", NBITS'(ifa.viol_cnt), '0);
    chk("rst_busy", NBITS'(ifa.busy), '0);
    tick();

    // SPI write into the control area; same-edge read still sees the old value.
    ifa.spi_wr_stb = 1'b1; ifa.spi_wr_addr = 9'd5; ifa.spi_wr_data = 1'b1; ifa.spi_rd_addr = 9'd5;
    #1 chk("rd_before", NBITS'(ifa.spi_rd_data), '0);
    tick();
    ifa.spi_wr_stb = 1'b0;
    exp_a[5] = 1'b1;
    chk("spi_wr5", ifa.reg_bits, exp_a);
    chk("rd5", NBITS'(ifa.spi_rd_data), NBITS'(1));
    chk("vcnt0", NBITS'(ifa.viol_cnt), '0);

    // SPI writes into the status area and beyond NBITS are dropped.
    c = cyc;
    ifa.spi_wr_stb = 1'b1; ifa.spi_wr_addr = 9'd250; ifa.spi_wr_data = 1'b1;
    push_a(c + 1, 2'b00, 1'b1, 8'd1);
    tick();
    ifa.spi_wr_addr = 9'd450;
    push_a(c + 2, 2'b00, 1'b1, 8'd2);
    exp_vc = 8'd2;
    tick();
    ifa.spi_wr_stb = 1'b0;
    ifa.spi_rd_addr = 9'd450;
    #1 chk("rd_oob", NBITS'(ifa.spi_rd_data), '0);
    tick();
    chk("spi_viol_bits", ifa.reg_bits, exp_a);

    // Two locals held together: grants one cycle apart with a gap; repeated to confirm pointer at 0.
    for (int r = 0; r < 2; r++) begin
      c = cyc;
      ifa.loc_req  = 2'b11;
      ifa.loc_addr = (r == 0) ? {9'd301, 9'd300} : {9'd303, 9'd302};
      ifa.loc_data = 2'b11;
      push_a(c + 1, 2'b01, 1'b0, exp_vc);
      push_a(c + 3, 2'b10, 1'b0, exp_vc);
      tick();
      ifa.loc_req = 2'b10;
      tick();
      tick();
      ifa.loc_req = 2'b00;
      tick();
      exp_a[300 + 2*r] = 1'b1;
      exp_a[301 + 2*r] = 1'b1;
      chk("rr_bits", ifa.reg_bits, exp_a);
    end

    // CS low locks out locals; grant resumes once SETTLE has run its 4 cycles.
    ifa.spi_cs_n = 1'b0;
    tick();
    ifa.loc_req = 2'b01; ifa.loc_addr = {9'd0, 9'd310}; ifa.loc_data = 2'b01;
    repeat (4) tick();
    chk("lock_busy", NBITS'(ifa.busy), NBITS'(1));
    c = cyc;
    ifa.spi_cs_n = 1'b1;
    push_a(c + 6, 2'b01, 1'b0, exp_vc);
    repeat (4) tick();
    chk("settle_busy", NBITS'(ifa.busy), NBITS'(1));
    tick();
    chk("idle_busy", NBITS'(ifa.busy), '0);
    tick();
    ifa.loc_req = 2'b00;
    exp_a[310] = 1'b1;
    chk("settle_bits", ifa.reg_bits, exp_a);

    // LOCK_DURING_SPI=0: SPI strobe wins the collision, local served the next cycle.
    c = cyc;
    ifb.spi_cs_n = 1'b0;
    ifb.spi_wr_stb = 1'b1; ifb.spi_wr_addr = 9'd7; ifb.spi_wr_data = 1'b1;
    ifb.loc_req = 2'b10; ifb.loc_addr = {9'd320, 9'd0}; ifb.loc_data = 2'b10;
    eb.cyc = c + 2; eb.gnt = 2'b10; eb.vp = 1'b0; eb.vc = 8'd0;
    qb.push_back(eb);
    tick();
    ifb.spi_wr_stb = 1'b0;
    exp_b[7] = 1'b1;
    chk("b_spi_first", ifb.reg_bits, exp_b);
    tick();
    ifb.loc_req = 2'b00;
    exp_b[320] = 1'b1;
    chk("b_loc_after", ifb.reg_bits, exp_b);
    ifb.spi_cs_n = 1'b1;

    // 300 protected local writes saturate the violation counter.
    tick();
    c = cyc;
    ifa.loc_req = 2'b01; ifa.loc_addr = {9'd0, 9'd10}; ifa.loc_data = 2'b01;
    for (int k = 0; k < 300; k++) begin
      exp_vc = (exp_vc == 8'hFF) ? 8'hFF : exp_vc + 8'd1;
      push_a(c + 1 + 2*k, 2'b01, 1'b1, exp_vc);
    end
    repeat (599) tick();
    ifa.loc_req = 2'b00;
    repeat (2) tick();
    chk("sat_vcnt", NBITS'(ifa.viol_cnt), NBITS'(255));
    chk("sat_bits", ifa.reg_bits, exp_a);

    // Reset in the middle of an SPI frame with requests pending.
    ifa.spi_cs_n = 1'b0;
    ifa.spi_wr_stb = 1'b1; ifa.spi_wr_addr = 9'd20; ifa.spi_wr_data = 1'b1;
    tick();
    ifa.spi_wr_stb = 1'b0;
    repeat (2) tick();
    chk("frame_busy", NBITS'(ifa.busy), NBITS'(1));
    rst_n = 1'b0;
    ifa.spi_cs_n = 1'b1;
    ifa.loc_req = 2'b11; ifa.loc_addr = {9'd331, 9'd330}; ifa.loc_data = 2'b11;
    #1;
    chk("mrst_bits", ifa.reg_bits, '0);
    chk("mrst_gnt", NBITS'(ifa.loc_gnt), '0);
    chk("mrst_vp", NBITS'(ifa.viol_pulse), '0);
    chk("mrst_vcnt", NBITS'(ifa.viol_cnt), '0);
    chk("mrst_busy", NBITS'(ifa.busy), '0);
    exp_a = '0; exp_vc = 8'd0;
    repeat (2) tick();
    c = cyc;
    rst_n = 1'b1;
    push_a(c + 1, 2'b01, 1'b0, 8'd0);
    push_a(c + 3, 2'b10, 1'b0, 8'd0);
    tick();
    ifa.loc_req = 2'b10;
    repeat (2) tick();
    ifa.loc_req = 2'b00;
    tick();
    exp_a[330] = 1'b1; exp_a[331] = 1'b1;
    chk("post_rst_bits", ifa.reg_bits, exp_a);

    repeat (3) tick();
    chk("qa_drained", NBITS'(qa.size()), '0);
    chk("qb_drained", NBITS'(qb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
